// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory byte-enable responder.
//   dmem_state_e : responder FSM states
//   BE_*         : the byte-enable patterns the responder will commit or read
//   be_legal()   : 1 when a byte-enable pattern is one of the BE_* values
package dmem_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StWait,
        StAccess,
        StResp
    } dmem_state_e;

    localparam logic [3:0] BE_B0 = 4'b0001;
    localparam logic [3:0] BE_B1 = 4'b0010;
    localparam logic [3:0] BE_B2 = 4'b0100;
    localparam logic [3:0] BE_B3 = 4'b1000;
    localparam logic [3:0] BE_H0 = 4'b0011;
    localparam logic [3:0] BE_H1 = 4'b1100;
    localparam logic [3:0] BE_W  = 4'b1111;

    // Only naturally aligned byte, halfword and word accesses are accepted.
    function automatic logic be_legal(input logic [3:0] be);
        logic ok;
        case (be)
            BE_B0, BE_B1, BE_B2, BE_B3, BE_H0, BE_H1, BE_W: ok = 1'b1;
            default:                                        ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/dmem_byte_array.sv
// Word-organised storage with four independently writable byte lanes.
//   clk   : clock
//   we    : per-lane write enable, bit k writes wdata[8k+7:8k]
//   re    : read enable; loads the addressed word into the read register
//   addr  : word index
//   wdata : lane-aligned write data
//   rdata : registered read data, holds its value while re is low
// Contents are not reset.
module dmem_byte_array #(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned MEM_AW      = 10
) (
    input  logic              clk,
    input  logic [3:0]        we,
    input  logic              re,
    input  logic [MEM_AW-1:0] addr,
    input  logic [31:0]       wdata,
    output logic [31:0]       rdata
);

    logic [3:0][7:0] mem [DEPTH_WORDS];
    logic [31:0]     rdata_q;

    always_ff @(posedge clk) begin
        for (int k = 0; k < 4; k++) begin
            if (we[k]) begin
                mem[addr][k] <= wdata[8*k +: 8];
            end
        end
        if (re) begin
            rdata_q <= mem[addr];
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/dmem_be_responder.sv
// Memory-side responder for the CPU byte-enable load/store path.
//   clk, reset_n          : clock, asynchronous active-low reset
//   req_valid / req_ready : request handshake; one request outstanding at a time
//   req_we                : 1 = store, 0 = load
//   req_addr              : byte address, bits [1:0] ignored
//   req_be                : byte enable, bit k selects req_wdata[8k+7:8k]
//   req_wdata             : lane-aligned store data
//   rsp_valid / rsp_ready : response handshake
//   rsp_rdata             : full word for loads, 0 for stores and errors
//   rsp_err               : illegal byte enable or word index out of range
// WAIT_CYCLES (0..15) wait states are inserted between accept and the array access.
module dmem_be_responder #(
    parameter int unsigned ADDR_W      = 12,
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned WAIT_CYCLES = 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [3:0]        req_be,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err
);

    import dmem_pkg::*;

    localparam int unsigned IDX_W  = ADDR_W - 2;
    localparam int unsigned MEM_AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [3:0]  WaitLast = 4'((WAIT_CYCLES == 0) ? 0 : WAIT_CYCLES - 1);

    dmem_state_e state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        err_q, err_d;
    logic        rd_sel_q, rd_sel_d;   // 1 when the response carries array read data

    logic             we_q;
    logic [IDX_W-1:0] idx_q;
    logic [3:0]       be_q;
    logic [31:0]      wdata_q;
    logic             capture;

    logic              access_ok;
    logic [3:0]        arr_we;
    logic              arr_re;
    logic [MEM_AW-1:0] arr_addr;
    logic [31:0]       arr_rdata;

    logic unused_addr_bits;
    assign unused_addr_bits = ^req_addr[1:0];

    assign access_ok = be_legal(be_q) && (32'(idx_q) < DEPTH_WORDS);
    assign arr_addr  = MEM_AW'(idx_q);

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        err_d    = err_q;
        rd_sel_d = rd_sel_q;
        capture  = 1'b0;
        arr_we   = 4'b0000;
        arr_re   = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (req_valid) begin
                    capture = 1'b1;
                    cnt_d   = 4'd0;
                    state_d = (WAIT_CYCLES == 0) ? StAccess : StWait;
                end
            end
            StWait: begin
                cnt_d = cnt_q + 4'd1;
                if (cnt_q == WaitLast) begin
                    state_d = StAccess;
                end
            end
            StAccess: begin
                // Errors never touch the array and always answer with zero data.
                err_d    = ~access_ok;
                rd_sel_d = access_ok & ~we_q;
                arr_we   = (access_ok & we_q) ? be_q : 4'b0000;
                arr_re   = access_ok & ~we_q;
                state_d  = StResp;
            end
            StResp: begin
                if (rsp_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= StIdle;
            cnt_q    <= 4'd0;
            err_q    <= 1'b0;
            rd_sel_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            err_q    <= err_d;
            rd_sel_q <= rd_sel_d;
        end
    end

    // Request fields are only sampled on the accepting edge.
    always_ff @(posedge clk) begin
        if (capture) begin
            we_q    <= req_we;
            idx_q   <= req_addr[ADDR_W-1:2];
            be_q    <= req_be;
            wdata_q <= req_wdata;
        end
    end

    dmem_byte_array #(
        .DEPTH_WORDS(DEPTH_WORDS),
        .MEM_AW     (MEM_AW)
    ) u_array (
        .clk  (clk),
        .we   (arr_we),
        .re   (arr_re),
        .addr (arr_addr),
        .wdata(wdata_q),
        .rdata(arr_rdata)
    );

    // reset_n gates ready so nothing is offered while the block is held in reset.
    assign req_ready = (state_q == StIdle) & reset_n;
    assign rsp_valid = (state_q == StResp);
    assign rsp_rdata = rd_sel_q ? arr_rdata : 32'h0;
    assign rsp_err   = err_q;

endmodule

// File: tb/tb_dmem_be_responder.sv
// Self-checking bench for dmem_be_responder: one instance with one wait state and one with
// none, a transaction-level reference model checked every cycle, and directed vectors.
module tb_dmem_be_responder;

    localparam int unsigned AW    = 13;
    localparam int unsigned DEPTH = 1024;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [1:0]          reset_n, req_valid, req_ready, req_we, rsp_valid, rsp_ready, rsp_err;
    logic [1:0][AW-1:0]  req_addr;
    logic [1:0][3:0]     req_be;
    logic [1:0][31:0]    req_wdata, rsp_rdata;

    dmem_be_responder #(.ADDR_W(AW), .DEPTH_WORDS(DEPTH), .WAIT_CYCLES(1)) dut_w1 (
        .clk(clk), .reset_n(reset_n[0]), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
        .req_we(req_we[0]), .req_addr(req_addr[0]), .req_be(req_be[0]),
        .req_wdata(req_wdata[0]), .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]),
        .rsp_rdata(rsp_rdata[0]), .rsp_err(rsp_err[0])
    );

    dmem_be_responder #(.ADDR_W(AW), .DEPTH_WORDS(DEPTH), .WAIT_CYCLES(0)) dut_w0 (
        .clk(clk), .reset_n(reset_n[1]), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
        .req_we(req_we[1]), .req_addr(req_addr[1]), .req_be(req_be[1]),
        .req_wdata(req_wdata[1]), .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]),
        .rsp_rdata(rsp_rdata[1]), .rsp_err(rsp_err[1])
    );

    int errors = 0;
    int checks = 0;

    function automatic int wait_of(input int d);
        return (d == 0) ? 1 : 0;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic timeout(input string name);
        checks++;
        errors++;
        $display("FAIL %s: timed out (t=%0t)", name, $time);
    endtask

    // Reference model: m_t counts edges since the request was accepted (-1 = idle).
    // The array access happens on edge WAIT_CYCLES+1, after which the response is up.
    int          m_t     [2] = '{-1, -1};
    logic [31:0] m_rdata [2] = '{32'h0, 32'h0};
    logic        m_err   [2] = '{1'b0, 1'b0};
    logic        m_we    [2];
    logic [AW-1:0] m_addr [2];
    logic [3:0]  m_be    [2];
    logic [31:0] m_wd    [2];
    logic [31:0] m_mem   [2][DEPTH];

    task automatic model_commit(input int d);
        int          idx;
        bit          legal;
        logic [31:0] mask;
        idx   = int'(m_addr[d] >> 2);
        legal = (m_be[d] inside {4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0011, 4'b1100, 4'b1111})
                && (idx < DEPTH);
        mask  = {{8{m_be[d][3]}}, {8{m_be[d][2]}}, {8{m_be[d][1]}}, {8{m_be[d][0]}}};
        m_err[d]   = ~legal;
        m_rdata[d] = 32'h0;
        if (legal && m_we[d]) m_mem[d][idx] = (m_mem[d][idx] & ~mask) | (m_wd[d] & mask);
        if (legal && !m_we[d]) m_rdata[d] = m_mem[d][idx];
    endtask

    initial forever begin
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            logic in_rst, exp_rdy, exp_vld;
            in_rst = (reset_n[d] !== 1'b1);
            if (in_rst) begin
                m_t[d]     = -1;
                m_rdata[d] = 32'h0;
                m_err[d]   = 1'b0;
            end
            exp_rdy = !in_rst && (m_t[d] < 0);
            exp_vld = !in_rst && (m_t[d] >= wait_of(d) + 1);
            check($sformatf("dut%0d req_ready", d), {31'b0, req_ready[d]}, {31'b0, exp_rdy});
            check($sformatf("dut%0d rsp_valid", d), {31'b0, rsp_valid[d]}, {31'b0, exp_vld});
            if (exp_vld || in_rst) begin
                check($sformatf("dut%0d rsp_rdata", d), rsp_rdata[d], m_rdata[d]);
                check($sformatf("dut%0d rsp_err", d), {31'b0, rsp_err[d]}, {31'b0, m_err[d]});
            end
            if (!in_rst) begin
                if (m_t[d] >= wait_of(d) + 1) begin
                    if (rsp_ready[d]) m_t[d] = -1;
                end else if (m_t[d] >= 0) begin
                    m_t[d]++;
                    if (m_t[d] == wait_of(d) + 1) model_commit(d);
                end else if (req_valid[d]) begin
                    m_we[d]   = req_we[d];
                    m_addr[d] = req_addr[d];
                    m_be[d]   = req_be[d];
                    m_wd[d]   = req_wdata[d];
                    m_t[d]    = 0;
                end
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 just after the accepting edge.
    task automatic accept(input int d, input bit we, input logic [AW-1:0] addr,
                          input logic [3:0] be, input logic [31:0] wd, output bit ok);
        req_valid[d] = 1'b1;
        req_we[d]    = we;
        req_addr[d]  = addr;
        req_be[d]    = be;
        req_wdata[d] = wd;
        ok = 1'b0;
        for (int n = 0; n < 20 && !ok; n++) begin
            @(negedge clk);
            if (req_ready[d] === 1'b1) ok = 1'b1;
            @(posedge clk);
            #1;
        end
        // Scramble the fields: the responder must have latched them already.
        req_valid[d] = 1'b0;
        req_we[d]    = ~we;
        req_addr[d]  = ~addr;
        req_be[d]    = 4'b1111;
        req_wdata[d] = ~wd;
        if (!ok) timeout($sformatf("dut%0d accept", d));
    endtask

    task automatic txn(input int d, input bit we, input logic [AW-1:0] addr, input logic [3:0] be,
                       input logic [31:0] wd, input int hold,
                       output logic [31:0] rd, output logic err);
        bit ok;
        int n;
        rd  = 32'hx;
        err = 1'bx;
        rsp_ready[d] = (hold == 0);
        accept(d, we, addr, be, wd, ok);
        if (!ok) begin
            rsp_ready[d] = 1'b1;
            return;
        end
        ok = 1'b0;
        for (n = 0; n < 40; n++) begin
            @(negedge clk);
            if (rsp_valid[d] === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            timeout($sformatf("dut%0d rsp_valid", d));
            rsp_ready[d] = 1'b1;
            @(posedge clk);
            #1;
            return;
        end
        check($sformatf("dut%0d latency", d), 32'(n), 32'(wait_of(d) + 1));
        rd  = rsp_rdata[d];
        err = rsp_err[d];
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            #1;
            // A request raised during the response phase must not be taken.
            req_valid[d] = 1'b1;
            req_we[d]    = 1'b1;
            req_addr[d]  = addr;
            req_be[d]    = 4'b1111;
            req_wdata[d] = 32'h1111_1111;
            @(negedge clk);
            check("bp rsp_valid", {31'b0, rsp_valid[d]}, 32'd1);
            check("bp rsp_rdata", rsp_rdata[d], rd);
            check("bp req_ready", {31'b0, req_ready[d]}, 32'd0);
        end
        if (hold > 0) begin
            @(posedge clk);
            #1;
            rsp_ready[d] = 1'b1;
        end
        @(posedge clk);
        #1;
        req_valid[d] = 1'b0;
        @(negedge clk);
        check($sformatf("dut%0d idle after rsp", d), {31'b0, req_ready[d]}, 32'd1);
        @(posedge clk);
        #1;
    endtask

    // Start a store, then pull reset right after it is accepted.
    task automatic txn_reset(input int d, input logic [AW-1:0] addr, input logic [31:0] wd);
        bit ok;
        accept(d, 1'b1, addr, 4'b1111, wd, ok);
        reset_n[d] = 1'b0;
        @(negedge clk);
        check("rst req_ready", {31'b0, req_ready[d]}, 32'd0);
        check("rst rsp_valid", {31'b0, rsp_valid[d]}, 32'd0);
        check("rst rsp_rdata", rsp_rdata[d], 32'h0);
        check("rst rsp_err", {31'b0, rsp_err[d]}, 32'd0);
        @(posedge clk);
        #1;
        reset_n[d] = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd;
        logic        er;
        reset_n   = 2'b00;
        req_valid = 2'b00;
        req_we    = 2'b00;
        req_addr  = '0;
        req_be    = '0;
        req_wdata = '0;
        rsp_ready = 2'b11;
        repeat (2) @(posedge clk);
        #1;
        reset_n = 2'b11;

        // Word store, then load back.
        txn(0, 1'b1, 13'h010, 4'b1111, 32'hDEAD_BEEF, 0, rd, er);
        check("s1 store err", {31'b0, er}, 32'd0);
        check("s1 store rdata", rd, 32'h0);
        txn(0, 1'b0, 13'h010, 4'b1111, 32'h0, 0, rd, er);
        check("s1 load rdata", rd, 32'hDEAD_BEEF);
        check("s1 load err", {31'b0, er}, 32'd0);

        // Single byte lane merge.
        txn(0, 1'b1, 13'h010, 4'b0100, 32'h00AA_0000, 0, rd, er);
        txn(0, 1'b0, 13'h010, 4'b1111, 32'h0, 0, rd, er);
        check("s2 merge", rd, 32'hDEAA_BEEF);

        // Upper halfword over an existing word.
        txn(0, 1'b1, 13'h040, 4'b1111, 32'h0000_5678, 0, rd, er);
        txn(0, 1'b1, 13'h040, 4'b1100, 32'h1234_0000, 0, rd, er);
        txn(0, 1'b0, 13'h042, 4'b1111, 32'h0, 0, rd, er);
        check("s3 halfword", rd, 32'h1234_5678);

        // Illegal byte enables and out-of-range index.
        txn(0, 1'b1, 13'h010, 4'b0101, 32'hFFFF_FFFF, 0, rd, er);
        check("s4 be0101 err", {31'b0, er}, 32'd1);
        check("s4 be0101 rdata", rd, 32'h0);
        txn(0, 1'b0, 13'h010, 4'b0000, 32'h0, 0, rd, er);
        check("s4 be0000 err", {31'b0, er}, 32'd1);
        txn(0, 1'b0, 13'h010, 4'b1111, 32'h0, 0, rd, er);
        check("s4 unchanged", rd, 32'hDEAA_BEEF);
        txn(0, 1'b1, 13'h1000, 4'b1111, 32'h5555_5555, 0, rd, er);
        check("s4 range store err", {31'b0, er}, 32'd1);
        txn(0, 1'b0, 13'h1000, 4'b1111, 32'h0, 0, rd, er);
        check("s4 range load err", {31'b0, er}, 32'd1);
        check("s4 range load rdata", rd, 32'h0);
        txn(0, 1'b0, 13'h000, 4'b1111, 32'h0, 0, rd, er);
        check("s4 no wrap to word 0", {31'b0, er}, 32'd0);

        // Backpressure with a late request that must be ignored.
        txn(0, 1'b0, 13'h010, 4'b1111, 32'h0, 5, rd, er);
        check("s5 bp rdata", rd, 32'hDEAA_BEEF);
        txn(0, 1'b0, 13'h010, 4'b1111, 32'h0, 0, rd, er);
        check("s5 late req ignored", rd, 32'hDEAA_BEEF);

        // Reset during the wait state drops the store.
        txn(0, 1'b1, 13'h020, 4'b1111, 32'h0, 0, rd, er);
        txn(0, 1'b0, 13'h010, 4'b1111, 32'h0, 0, rd, er);
        txn_reset(0, 13'h020, 32'hCAFE_F00D);
        txn(0, 1'b0, 13'h020, 4'b1111, 32'h0, 0, rd, er);
        check("s6 w1 dropped", rd, 32'h0);

        // Zero wait states.
        txn(1, 1'b1, 13'h020, 4'b1111, 32'h0, 0, rd, er);
        txn(1, 1'b1, 13'h030, 4'b1111, 32'hA5A5_5A5A, 0, rd, er);
        txn(1, 1'b1, 13'h030, 4'b0001, 32'h0000_00C3, 0, rd, er);
        txn(1, 1'b0, 13'h030, 4'b1111, 32'h0, 0, rd, er);
        check("w0 byte0 merge", rd, 32'hA5A5_5AC3);
        txn_reset(1, 13'h020, 32'hCAFE_F00D);
        txn(1, 1'b0, 13'h020, 4'b1111, 32'h0, 0, rd, er);
        check("s6 w0 dropped", rd, 32'h0);

        repeat (2) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
